// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - drains FIFO words onto a UART line: start, LSB-first data, stop.
// Define UART_TX_DRAIN_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic                  i_FifoCanRead,
  output logic                  o_FifoRdEnable,
  input  logic [DATA_WIDTH-1:0] i_FifoRdData,
  output logic                  o_Tx,
  output logic                  o_Busy,
  output logic                  o_Done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd6
`ifdef UART_TX_DRAIN_PARITY_EN
    , ST_PARITY = 3'd5
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
`ifdef UART_TX_DRAIN_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic                  baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_Enable && i_FifoCanRead) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: if (baud_last) state_d = ST_DATA;
      ST_DATA: begin
        if (baud_last && (bit_q == BIT_LAST)) begin
`ifdef UART_TX_DRAIN_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_DRAIN_PARITY_EN
      ST_PARITY: if (baud_last) state_d = ST_STOP;
`endif
      ST_STOP:  if (baud_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Baud counter restarts on every state entry and on every bit boundary.
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef UART_TX_DRAIN_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q == ST_IDLE || state_d != state_q || baud_last) baud_d = '0;
    else baud_d = baud_q + 1'b1;
    if (state_q == ST_LOAD) begin
      shift_d = i_FifoRdData;
      bit_d   = '0;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_d = 1'b0;
`endif
    end else if (state_q == ST_DATA && baud_last) begin
      shift_d = shift_q >> 1;
      bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity_d = parity_q ^ shift_q[0];
`endif
    end
  end

  always_comb begin
    o_Tx           = 1'b1;
    o_FifoRdEnable = 1'b0;
    o_Done         = 1'b0;
    o_Busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_FETCH:  o_FifoRdEnable = 1'b1;
      ST_START:  o_Tx = 1'b0;
      ST_DATA:   o_Tx = shift_q[0];
`ifdef UART_TX_DRAIN_PARITY_EN
      ST_PARITY: o_Tx = parity_q;
`endif
      ST_STOP:   o_Done = baud_last;
      default:   o_Tx = 1'b1;
    endcase
  end

endmodule
